// File: rtl/pcie_rq_responder.sv
// -----------------------------------------------------------------------------
// pcie_rq_responder
// Completer-side stand-in for the PCIe core on the controller's read/write
// request channels. Requests are serviced from an internal 128-bit host
// memory after LATENCY cycles and answered with one-cycle Ready/Err pulses.
//
// Parameters:
//   DEPTH     - number of 128-bit host-memory words (power of two, >= 2)
//   BASE_ADDR - byte address of word 0 (16-byte aligned)
//   LATENCY   - cycles from acceptance to response pulse (1..63)
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   RdRqValid, RdRqAddr             - read request, held until Ready/Err
//   RdRqData, RdRqReady, RdRqErr    - read data (held between reads), pulses
//   WrRqValid, WrRqAddr, WrRqData   - write request, held until Ready/Err
//   WrRqReady, WrRqErr              - write committed / rejected pulses
//   ErrInj                          - forces an error on the request accepted
//                                     this cycle (only with the macro below)
//
// Optional feature: define PCIE_RQ_RESP_ERRINJ_EN to add the ErrInj port.
// -----------------------------------------------------------------------------
module pcie_rq_responder #(
   parameter int          DEPTH     = 256,
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int          LATENCY   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         RdRqValid,
   input  logic [63:0]  RdRqAddr,
   output logic [127:0] RdRqData,
   output logic         RdRqReady,
   output logic         RdRqErr,
   input  logic         WrRqValid,
   input  logic [63:0]  WrRqAddr,
   input  logic [127:0] WrRqData,
   output logic         WrRqReady,
   output logic         WrRqErr
`ifdef PCIE_RQ_RESP_ERRINJ_EN
   ,
   input  logic         ErrInj
`endif
);

   localparam int          IDX_W     = $clog2(DEPTH);
   localparam logic [64:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [64:0] LIMIT_EXT = BASE_EXT + (65'(DEPTH) << 4);
   localparam logic [5:0]  LOAD_VAL  = 6'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t             state_r, state_n;
   logic [5:0]         cnt_r;
   logic               rd_arm_r, wr_arm_r;
   logic               last_wr_r;        // last served channel was the write channel
   logic               err_r;
   logic [IDX_W-1:0]   idx_r;
   logic [127:0]       wdata_r;
   logic [127:0]       mem_r [DEPTH];
   logic [127:0]       rd_data_r;
   logic               rd_ready_r, rd_err_r, wr_ready_r, wr_err_r;

   logic               accept_rd_s, accept_wr_s;
   logic               rd_resp_s, wr_resp_s, dec_s;
   logic [63:0]        addr_sel_s;
   logic               acc_err_s;
   logic [IDX_W-1:0]   acc_idx_s;
   logic               inj_s;

   // Out-of-window check done in 65 bits so a window touching 2^64 cannot wrap.
   function automatic logic addr_err_f(input logic [63:0] addr);
      logic [64:0] addr_ext;
      addr_ext = {1'b0, addr};
      return (addr[3:0] != 4'd0) || (addr_ext < BASE_EXT) || (addr_ext >= LIMIT_EXT);
   endfunction

`ifdef PCIE_RQ_RESP_ERRINJ_EN
   assign inj_s = ErrInj;
`else
   assign inj_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic: arbitration in IDLE, abort/countdown/response in WAIT.
   always_comb begin
      state_n     = state_r;
      accept_rd_s = 1'b0;
      accept_wr_s = 1'b0;
      rd_resp_s   = 1'b0;
      wr_resp_s   = 1'b0;
      dec_s       = 1'b0;
      case (state_r)
         IDLE: begin
            // On a tie the read goes first unless it was served last.
            if (RdRqValid && rd_arm_r && (!(WrRqValid && wr_arm_r) || last_wr_r)) begin
               accept_rd_s = 1'b1;
               state_n     = RD_WAIT;
            end else if (WrRqValid && wr_arm_r) begin
               accept_wr_s = 1'b1;
               state_n     = WR_WAIT;
            end else begin
               state_n = IDLE;
            end
         end
         RD_WAIT: begin
            if (!RdRqValid) begin
               state_n = IDLE;
            end else if (cnt_r == 6'd0) begin
               rd_resp_s = 1'b1;
               state_n   = IDLE;
            end else begin
               dec_s = 1'b1;
            end
         end
         WR_WAIT: begin
            if (!WrRqValid) begin
               state_n = IDLE;
            end else if (cnt_r == 6'd0) begin
               wr_resp_s = 1'b1;
               state_n   = IDLE;
            end else begin
               dec_s = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Decode of the request being accepted: address mux, error, word index.
   always_comb begin
      addr_sel_s = RdRqAddr;
      if (accept_wr_s) begin
         addr_sel_s = WrRqAddr;
      end else begin
         addr_sel_s = RdRqAddr;
      end
      acc_err_s = addr_err_f(addr_sel_s) || inj_s;
      acc_idx_s = IDX_W'((addr_sel_s - BASE_ADDR) >> 4);
   end

   // Request context, latency counter, arm flags and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= 6'd0;
         idx_r     <= '0;
         err_r     <= 1'b0;
         wdata_r   <= 128'd0;
         last_wr_r <= 1'b1;
         rd_arm_r  <= 1'b1;
         wr_arm_r  <= 1'b1;
      end else begin
         if (accept_rd_s || accept_wr_s) begin
            cnt_r     <= LOAD_VAL;
            idx_r     <= acc_idx_s;
            err_r     <= acc_err_s;
            last_wr_r <= accept_wr_s;
         end else if (dec_s) begin
            cnt_r <= cnt_r - 6'd1;
         end
         if (accept_wr_s) begin
            wdata_r <= WrRqData;
         end
         // A held request must be dropped before the channel can be re-armed.
         if (!RdRqValid) begin
            rd_arm_r <= 1'b1;
         end else if (rd_resp_s) begin
            rd_arm_r <= 1'b0;
         end
         if (!WrRqValid) begin
            wr_arm_r <= 1'b1;
         end else if (wr_resp_s) begin
            wr_arm_r <= 1'b0;
         end
      end
   end

   // Registered response pulses and read data (held between read responses).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r  <= 128'd0;
         rd_ready_r <= 1'b0;
         rd_err_r   <= 1'b0;
         wr_ready_r <= 1'b0;
         wr_err_r   <= 1'b0;
      end else begin
         rd_ready_r <= rd_resp_s && !err_r;
         rd_err_r   <= rd_resp_s && err_r;
         wr_ready_r <= wr_resp_s && !err_r;
         wr_err_r   <= wr_resp_s && err_r;
         if (rd_resp_s) begin
            rd_data_r <= err_r ? 128'd0 : mem_r[idx_r];
         end
      end
   end

   // Host memory: written at the write response edge, never reset.
   always_ff @(posedge clk) begin
      if (wr_resp_s && !err_r) begin
         mem_r[idx_r] <= wdata_r;
      end
   end

   assign RdRqData  = rd_data_r;
   assign RdRqReady = rd_ready_r;
   assign RdRqErr   = rd_err_r;
   assign WrRqReady = wr_ready_r;
   assign WrRqErr   = wr_err_r;

endmodule

// File: tb/tb_pcie_rq_responder.sv
// -----------------------------------------------------------------------------
// tb_pcie_rq_responder
// Self-checking bench: a transaction-level model (absolute due times, array
// memory) predicts every output each cycle, plus literal directed checks.
// -----------------------------------------------------------------------------
module tb_pcie_rq_responder;

   localparam int          DEPTH = 16;
   localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
   localparam int          LAT   = 4;
   localparam logic [127:0] PAT  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         RdRqValid = 1'b0;
   logic [63:0]  RdRqAddr = 64'd0;
   logic [127:0] RdRqData;
   logic         RdRqReady, RdRqErr;
   logic         WrRqValid = 1'b0;
   logic [63:0]  WrRqAddr = 64'd0;
   logic [127:0] WrRqData = 128'd0;
   logic         WrRqReady, WrRqErr;
`ifdef PCIE_RQ_RESP_ERRINJ_EN
   logic         ErrInj = 1'b0;
`endif

   always #5 clk = ~clk;

   pcie_rq_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .RdRqValid(RdRqValid), .RdRqAddr(RdRqAddr), .RdRqData(RdRqData),
      .RdRqReady(RdRqReady), .RdRqErr(RdRqErr),
      .WrRqValid(WrRqValid), .WrRqAddr(WrRqAddr), .WrRqData(WrRqData),
      .WrRqReady(WrRqReady), .WrRqErr(WrRqErr)
`ifdef PCIE_RQ_RESP_ERRINJ_EN
      , .ErrInj(ErrInj)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   // ---------------- inputs as seen at each rising edge ----------------
   logic s_rst = 1'b0, s_rv = 1'b0, s_wv = 1'b0, s_inj = 1'b0;
   logic [63:0]  s_ra = 64'd0, s_wa = 64'd0;
   logic [127:0] s_wd = 128'd0;

   always @(posedge clk) begin
      s_rst <= rst_n;
      s_rv  <= RdRqValid;
      s_wv  <= WrRqValid;
      s_ra  <= RdRqAddr;
      s_wa  <= WrRqAddr;
      s_wd  <= WrRqData;
`ifdef PCIE_RQ_RESP_ERRINJ_EN
      s_inj <= ErrInj;
`else
      s_inj <= 1'b0;
`endif
   end

   function automatic bit bad_addr(input logic [63:0] a);
      if (a[3:0] != 4'd0) return 1'b1;
      if (a < BASE) return 1'b1;
      return (a - BASE) >= 64'(16 * DEPTH);
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   logic [127:0] mmem [DEPTH];
   logic         e_rr = 1'b0, e_re = 1'b0, e_wr = 1'b0, e_we = 1'b0;
   logic [127:0] e_rd = 128'd0;

   initial begin
      int cyc, due, m_idx;
      bit busy, ch_wr, m_err, rd_arm, wr_arm, last_wr, rd_ok, wr_ok, pick;
      logic [63:0]  a;
      logic [127:0] m_wd;
      cyc = 0; due = 0; m_idx = 0; busy = 0; ch_wr = 0; m_err = 0;
      rd_arm = 1; wr_arm = 1; last_wr = 1; m_wd = 128'd0;
      forever begin
         @(negedge clk);
         if (!s_rst) begin
            busy = 0; rd_arm = 1; wr_arm = 1; last_wr = 1;
            e_rr = 0; e_re = 0; e_wr = 0; e_we = 0; e_rd = 128'd0;
         end else begin
            cyc++;
            e_rr = 0; e_re = 0; e_wr = 0; e_we = 0;
            if (busy) begin
               if (!(ch_wr ? s_wv : s_rv)) begin
                  busy = 0;
               end else if (cyc == due) begin
                  busy = 0;
                  if (ch_wr) begin
                     if (m_err) e_we = 1;
                     else begin e_wr = 1; mmem[m_idx] = m_wd; end
                     wr_arm = 0;
                  end else begin
                     if (m_err) begin e_re = 1; e_rd = 128'd0; end
                     else begin e_rr = 1; e_rd = mmem[m_idx]; end
                     rd_arm = 0;
                  end
               end
            end else begin
               rd_ok = s_rv && rd_arm;
               wr_ok = s_wv && wr_arm;
               if (rd_ok || wr_ok) begin
                  pick    = (rd_ok && wr_ok) ? !last_wr : wr_ok;
                  busy    = 1;
                  ch_wr   = pick;
                  last_wr = pick;
                  due     = cyc + LAT;
                  a       = pick ? s_wa : s_ra;
                  m_err   = bad_addr(a) || s_inj;
                  m_idx   = m_err ? 0 : int'((a - BASE) / 64'd16);
                  m_wd    = s_wd;
               end
            end
            if (!s_rv) rd_arm = 1;
            if (!s_wv) wr_arm = 1;
         end
         chk("RdRqReady", {127'd0, RdRqReady}, {127'd0, e_rr});
         chk("RdRqErr",   {127'd0, RdRqErr},   {127'd0, e_re});
         chk("WrRqReady", {127'd0, WrRqReady}, {127'd0, e_wr});
         chk("WrRqErr",   {127'd0, WrRqErr},   {127'd0, e_we});
         chk("RdRqData",  RdRqData, e_rd);
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic wr_req(input logic [63:0] a, input logic [127:0] d, input logic inj,
                         input int abort_after, output int lat, output logic ok, output logic er);
      @(negedge clk);
      WrRqValid = 1'b1; WrRqAddr = a; WrRqData = d;
`ifdef PCIE_RQ_RESP_ERRINJ_EN
      ErrInj = inj;
`endif
      lat = -1; ok = 1'b0; er = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (WrRqReady || WrRqErr) begin
            ok = WrRqReady; er = WrRqErr; lat = i - 1;
            break;
         end
         if (i == abort_after) break;
      end
      WrRqValid = 1'b0;
`ifdef PCIE_RQ_RESP_ERRINJ_EN
      ErrInj = 1'b0;
`endif
      if (lat < 0 && abort_after == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wr_timeout: got no response expected a pulse within 60 cycles");
      end
   endtask

   task automatic rd_req(input logic [63:0] a, input int abort_after, output int lat,
                         output logic ok, output logic er, output logic [127:0] d);
      @(negedge clk);
      RdRqValid = 1'b1; RdRqAddr = a;
      lat = -1; ok = 1'b0; er = 1'b0; d = 128'd0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (RdRqReady || RdRqErr) begin
            ok = RdRqReady; er = RdRqErr; d = RdRqData; lat = i - 1;
            break;
         end
         if (i == abort_after) break;
      end
      RdRqValid = 1'b0;
      if (lat < 0 && abort_after == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL rd_timeout: got no response expected a pulse within 60 cycles");
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0; RdRqValid = 1'b0; WrRqValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0: return BASE + 64'(16 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 15));
         1: return BASE + 64'(16 * DEPTH) + 64'(16 * $urandom_range(0, 3));
         2: return BASE - 64'(16 * $urandom_range(1, 4));
         3: return {$urandom, $urandom};
         default: return BASE + 64'(16 * $urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int lat, lat2, rd_t, wr_t, cnt;
      logic ok, er, ok2, er2;
      logic [127:0] d;

      repeat (3) @(negedge clk);
      chk("rst_RdRqData", RdRqData, 128'd0);
      chk("rst_RdRqReady", {127'd0, RdRqReady}, 128'd0);
      chk("rst_WrRqReady", {127'd0, WrRqReady}, 128'd0);
      #2 rst_n = 1'b1;

      for (int k = 0; k < DEPTH; k++)
         wr_req(BASE + 64'(16 * k), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, lat, ok, er);

      // Basic write then read-back, latency pinned.
      wr_req(BASE + 64'h40, PAT, 1'b0, 0, lat, ok, er);
      chk("wr40_lat", 128'(lat), 128'd4);
      chk("wr40_ok", {127'd0, ok}, 128'd1);
      rd_req(BASE + 64'h40, 0, lat, ok, er, d);
      chk("rd40_lat", 128'(lat), 128'd4);
      chk("rd40_data", d, PAT);

      // Address errors.
      rd_req(BASE + 64'h08, 0, lat, ok, er, d);
      chk("rd_misalign_err", {127'd0, er}, 128'd1);
      chk("rd_misalign_data", d, 128'd0);
      rd_req(BASE + 64'(16 * DEPTH), 0, lat, ok, er, d);
      chk("rd_top_err", {127'd0, er}, 128'd1);
      rd_req(BASE - 64'h10, 0, lat, ok, er, d);
      chk("rd_below_err", {127'd0, er}, 128'd1);
      wr_req(BASE + 64'(16 * DEPTH), 128'hDEAD, 1'b0, 0, lat, ok, er);
      chk("wr_top_err", {127'd0, er}, 128'd1);

      // Tie after reset: read first, write accepted right after read response.
      do_reset();
      @(negedge clk);
      RdRqValid = 1'b1; RdRqAddr = BASE + 64'h40;
      WrRqValid = 1'b1; WrRqAddr = BASE + 64'h50; WrRqData = ~PAT;
      rd_t = -1; wr_t = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (RdRqReady && rd_t < 0) begin rd_t = i; d = RdRqData; RdRqValid = 1'b0; end
         if (WrRqReady && wr_t < 0) begin wr_t = i; WrRqValid = 1'b0; end
         if (rd_t > 0 && wr_t > 0) break;
      end
      RdRqValid = 1'b0; WrRqValid = 1'b0;
      chk("tie_rd_time", 128'(rd_t), 128'd5);
      chk("tie_wr_time", 128'(wr_t), 128'd10);
      chk("tie_rd_data_retained", d, PAT);

      // Held Valid after a response is not re-accepted.
      @(negedge clk);
      RdRqValid = 1'b1; RdRqAddr = BASE + 64'h40;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (RdRqReady || RdRqErr) begin lat = i - 1; break; end
      end
      chk("hold_first_lat", 128'(lat), 128'd4);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (RdRqReady || RdRqErr) cnt++;
      end
      chk("hold_no_repeat", 128'(cnt), 128'd0);
      RdRqValid = 1'b0;
      rd_req(BASE + 64'h40, 0, lat, ok, er, d);
      chk("hold_rearm_lat", 128'(lat), 128'd4);

      // Aborted write leaves the word alone.
      wr_req(BASE + 64'h40, 128'h5555, 1'b0, 3, lat, ok, er);
      chk("abort_no_pulse", {126'd0, ok, er}, 128'd0);
      rd_req(BASE + 64'h40, 0, lat, ok, er, d);
      chk("abort_word_kept", d, PAT);

      // Reset during read wait.
      @(negedge clk);
      RdRqValid = 1'b1; RdRqAddr = BASE + 64'h40;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0; RdRqValid = 1'b0;
      #1;
      chk("rstmid_data", RdRqData, 128'd0);
      chk("rstmid_pulses", {124'd0, RdRqReady, RdRqErr, WrRqReady, WrRqErr}, 128'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (RdRqReady || RdRqErr) cnt++;
      end
      chk("rstmid_no_pulse", 128'(cnt), 128'd0);

`ifdef PCIE_RQ_RESP_ERRINJ_EN
      wr_req(BASE + 64'h40, ~PAT, 1'b1, 0, lat, ok, er);
      chk("inj_err", {126'd0, ok, er}, 128'd1);
      rd_req(BASE + 64'h40, 0, lat, ok, er, d);
      chk("inj_word_kept", d, PAT);
      wr_req(BASE + 64'h40, PAT, 1'b0, 0, lat, ok, er);
      chk("noinj_ok", {126'd0, ok, er}, 128'd2);
`endif

      // Randomized traffic, checked cycle by cycle by the model.
      for (int n = 0; n < 250; n++) begin
         int op;
         logic inj;
         op  = $urandom_range(0, 9);
         inj = ($urandom_range(0, 9) == 0);
         if (op <= 3) begin
            wr_req(rand_addr(), {$urandom, $urandom, $urandom, $urandom}, inj, 0, lat, ok, er);
         end else if (op <= 7) begin
            rd_req(rand_addr(), 0, lat, ok, er, d);
         end else if (op == 8) begin
            fork
               rd_req(rand_addr(), 0, lat, ok, er, d);
               wr_req(rand_addr(), {$urandom, $urandom, $urandom, $urandom}, inj, 0, lat2, ok2, er2);
            join
         end else begin
            wr_req(rand_addr(), {$urandom, $urandom}, inj, $urandom_range(1, 6), lat, ok, er);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected end within 100000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
